// File: rtl/console_arbiter.sv
// Two-port console arbiter: per-port one-byte output holding buffers drained
// round-robin to a single console, with console input routed to the focused port.
module console_arbiter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DATA_WIDTH-1:0] P0_COUT,
  input  logic [DATA_WIDTH-1:0] P1_COUT,
  input  logic                  P0_CWR,
  input  logic                  P1_CWR,
  output logic                  P0_CRDY,
  output logic                  P1_CRDY,
  output logic [DATA_WIDTH-1:0] P0_CIN,
  output logic [DATA_WIDTH-1:0] P1_CIN,
  output logic                  P0_CRDA,
  output logic                  P1_CRDA,
  input  logic                  P0_CACK,
  input  logic                  P1_CACK,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DWR,
  input  logic                  DRDY,
  input  logic [DATA_WIDTH-1:0] DIN,
  input  logic                  DRDA,
  output logic                  DACK,
  output logic [1:0]            ERR
);

  typedef enum logic {IDLE, GAP} state_t;

  state_t                state;
  logic [1:0]            buf_v;
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic [DATA_WIDTH-1:0] cout_c [2];
  logic [1:0]            cwr_c;
  logic                  rr;
  logic                  focus;
  logic                  sel_c;
  logic                  drain_c;

  assign cout_c[0] = P0_COUT;
  assign cout_c[1] = P1_COUT;
  assign cwr_c     = {P1_CWR, P0_CWR};

  // Round-robin pick: favour rr, fall back to the other port if rr is empty.
  assign sel_c   = buf_v[rr] ? rr : ~rr;
  assign drain_c = (state == IDLE) && DRDY && (|buf_v);

  assign P0_CRDY = ~buf_v[0];
  assign P1_CRDY = ~buf_v[1];

  // Input path: data is shared, availability and acknowledge follow focus.
  assign P0_CIN  = DIN;
  assign P1_CIN  = DIN;
  assign P0_CRDA = DRDA & ~focus;
  assign P1_CRDA = DRDA & focus;
  assign DACK    = DRDA & (focus ? P1_CACK : P0_CACK);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      buf_v <= 2'b00;
      for (int i = 0; i < 2; i++) buf_d[i] <= '0;
      DOUT  <= '0;
      DWR   <= 1'b0;
      rr    <= 1'b0;
      focus <= 1'b0;
      ERR   <= 2'b00;
    end else begin
      DWR <= 1'b0;
      if (state == IDLE) begin
        if (drain_c) begin
          DOUT         <= buf_d[sel_c];
          DWR          <= 1'b1;
          buf_v[sel_c] <= 1'b0;
          rr           <= ~sel_c;
          focus        <= sel_c;
          state        <= GAP;
        end
      end else begin
        state <= IDLE;
      end
      // A write against a full buffer is an overrun even if the buffer drains this edge.
      for (int i = 0; i < 2; i++) begin
        if (cwr_c[i]) begin
          if (buf_v[i]) begin
            ERR[i] <= 1'b1;
          end else begin
            buf_d[i] <= cout_c[i];
            buf_v[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_console_arbiter.sv
// Directed, table-driven bench for console_arbiter with hand-written
// sequences for reset abort, contention from reset and backpressure.
module tb_console_arbiter;

  logic       CLK;
  logic       RESET;
  logic [7:0] P0_COUT, P1_COUT;
  logic       P0_CWR, P1_CWR;
  logic       P0_CRDY, P1_CRDY;
  logic [7:0] P0_CIN, P1_CIN;
  logic       P0_CRDA, P1_CRDA;
  logic       P0_CACK, P1_CACK;
  logic [7:0] DOUT;
  logic       DWR;
  logic       DRDY;
  logic [7:0] DIN;
  logic       DRDA;
  logic       DACK;
  logic [1:0] ERR;

  console_arbiter #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET),
    .P0_COUT(P0_COUT), .P1_COUT(P1_COUT),
    .P0_CWR(P0_CWR), .P1_CWR(P1_CWR),
    .P0_CRDY(P0_CRDY), .P1_CRDY(P1_CRDY),
    .P0_CIN(P0_CIN), .P1_CIN(P1_CIN),
    .P0_CRDA(P0_CRDA), .P1_CRDA(P1_CRDA),
    .P0_CACK(P0_CACK), .P1_CACK(P1_CACK),
    .DOUT(DOUT), .DWR(DWR), .DRDY(DRDY),
    .DIN(DIN), .DRDA(DRDA), .DACK(DACK), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       cwr0;
    logic       cwr1;
    logic [7:0] cout0;
    logic [7:0] cout1;
    logic       drdy;
    logic       drda;
    logic [7:0] din;
    logic       cack0;
    logic       cack1;
    logic       crdy0;
    logic       crdy1;
    logic       dwr;
    logic [7:0] dout;
    logic       crda0;
    logic       crda1;
    logic       dack;
    logic [1:0] err;
  } vec_t;

  localparam int NV = 23;
  vec_t vtab [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    P0_CWR = 0; P1_CWR = 0; P0_COUT = 0; P1_COUT = 0;
    P0_CACK = 0; P1_CACK = 0; DRDA = 0; DIN = 0; DRDY = 0;
  endtask

  task automatic wait_dwr(input int max, output logic found);
    found = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge CLK); #1;
      if (DWR) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic        found;
    logic [31:0] act;
    logic [31:0] exp;
    int          bad_cycles;

    //         cwr0 cwr1 cout0  cout1  drdy drda din   ck0 ck1 | rdy0 rdy1 dwr dout   crda0 crda1 dack err
    vtab[0]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,8'h11,1'b1,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,1'b1,2'b00};
    vtab[1]  = '{1'b1,1'b0,8'h48,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,2'b00};
    vtab[2]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,2'b00};
    vtab[3]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b1,8'h48,1'b0,1'b0,1'b0,2'b00};
    vtab[4]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,8'h48,1'b0,1'b0,1'b0,2'b00};
    vtab[5]  = '{1'b1,1'b1,8'h41,8'h42,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,8'h48,1'b0,1'b0,1'b0,2'b00};
    vtab[6]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b0,1'b0,8'h48,1'b0,1'b0,1'b0,2'b00};
    vtab[7]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,1'b1,8'h42,1'b0,1'b0,1'b0,2'b00};
    vtab[8]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h42,1'b0,1'b0,1'b0,2'b00};
    vtab[9]  = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b1,8'h41,1'b0,1'b0,1'b0,2'b00};
    vtab[10] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,8'h41,1'b0,1'b1, 1'b1,1'b1,1'b0,8'h41,1'b1,1'b0,1'b0,2'b00};
    vtab[11] = '{1'b1,1'b0,8'h33,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,8'h41,1'b0,1'b0,1'b0,2'b00};
    vtab[12] = '{1'b1,1'b0,8'h55,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h41,1'b0,1'b0,1'b0,2'b00};
    vtab[13] = '{1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h41,1'b0,1'b0,1'b0,2'b01};
    vtab[14] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b0,1'b1,1'b0,8'h41,1'b0,1'b0,1'b0,2'b01};
    vtab[15] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b1,8'h33,1'b0,1'b0,1'b0,2'b01};
    vtab[16] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,8'h33,1'b0,1'b0,1'b0,2'b01};
    vtab[17] = '{1'b0,1'b1,8'h00,8'hA1,1'b0,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,8'h33,1'b0,1'b0,1'b0,2'b01};
    vtab[18] = '{1'b0,1'b1,8'h00,8'hB2,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b0,1'b0,8'h33,1'b0,1'b0,1'b0,2'b01};
    vtab[19] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b1,8'hA1,1'b0,1'b0,1'b0,2'b11};
    vtab[20] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,8'h7E,1'b1,1'b0, 1'b1,1'b1,1'b0,8'hA1,1'b0,1'b1,1'b0,2'b11};
    vtab[21] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,8'h7E,1'b0,1'b1, 1'b1,1'b1,1'b0,8'hA1,1'b0,1'b1,1'b1,2'b11};
    vtab[22] = '{1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h00,1'b0,1'b0, 1'b1,1'b1,1'b0,8'hA1,1'b0,1'b0,1'b0,2'b11};

    clr();
    RESET = 1'b0;
    @(negedge CLK);
    #1;
    chk("reset_state", {P0_CRDY, P1_CRDY, DWR, DOUT, ERR}, {1'b1, 1'b1, 1'b0, 8'h00, 2'b00});
    @(negedge CLK);
    RESET = 1'b1;

    // Table-driven vectors: drive at negedge, compare mid-cycle.
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      P0_CWR = vtab[i].cwr0;   P1_CWR = vtab[i].cwr1;
      P0_COUT = vtab[i].cout0; P1_COUT = vtab[i].cout1;
      DRDY = vtab[i].drdy;     DRDA = vtab[i].drda;   DIN = vtab[i].din;
      P0_CACK = vtab[i].cack0; P1_CACK = vtab[i].cack1;
      #1;
      act = {P0_CRDY, P1_CRDY, DWR, DOUT, P0_CRDA, P1_CRDA, DACK, ERR, P0_CIN, P1_CIN};
      exp = {vtab[i].crdy0, vtab[i].crdy1, vtab[i].dwr, vtab[i].dout,
             vtab[i].crda0, vtab[i].crda1, vtab[i].dack, vtab[i].err, vtab[i].din, vtab[i].din};
      chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
    end

    // Reset asserted during a DWR pulse aborts it and discards the pending byte.
    @(negedge CLK);
    clr();
    P0_CWR = 1; P0_COUT = 8'h5A; P1_CWR = 1; P1_COUT = 8'h5B; DRDY = 1;
    @(negedge CLK);
    P0_CWR = 0; P1_CWR = 0;
    wait_dwr(4, found);
    chk("rst_dwr_seen", 64'(found), 64'd1);
    RESET = 1'b0;
    #1;
    chk("rst_abort", {P0_CRDY, P1_CRDY, DWR, DOUT, ERR}, {1'b1, 1'b1, 1'b0, 8'h00, 2'b00});
    @(negedge CLK);
    RESET = 1'b1;
    DRDY = 0; DRDA = 1; DIN = 8'h3C;
    #1;
    chk("rst_focus0", {P0_CRDA, P1_CRDA, P0_CIN}, {1'b1, 1'b0, 8'h3C});

    // Simultaneous writes from reset: port 0 first, port 1 two cycles later.
    @(negedge CLK);
    clr();
    P0_CWR = 1; P0_COUT = 8'h41; P1_CWR = 1; P1_COUT = 8'h42; DRDY = 1;
    @(negedge CLK);
    P0_CWR = 0; P1_CWR = 0;
    wait_dwr(4, found);
    chk("cont_first", {found, DOUT}, {1'b1, 8'h41});
    @(negedge CLK); #1;
    chk("cont_gap", 64'(DWR), 64'd0);
    @(negedge CLK); #1;
    chk("cont_second", {DWR, DOUT}, {1'b1, 8'h42});
    DRDA = 1; DIN = 8'h41; P0_CACK = 1;
    #1;
    chk("cont_focus1_p0ack", {P0_CRDA, P1_CRDA, DACK}, {1'b0, 1'b1, 1'b0});
    P0_CACK = 0; P1_CACK = 1;
    #1;
    chk("cont_focus1_p1ack", {P1_CIN, DACK}, {8'h41, 1'b1});

    // Backpressure: both buffers full, console not ready for 10 cycles.
    @(negedge CLK);
    clr();
    P0_CWR = 1; P0_COUT = 8'h61; P1_CWR = 1; P1_COUT = 8'h62;
    @(negedge CLK);
    P0_CWR = 0; P1_CWR = 0;
    bad_cycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK); #1;
      if (DWR || P0_CRDY || P1_CRDY) bad_cycles++;
    end
    chk("bp_stall", 64'(bad_cycles), 64'd0);
    DRDY = 1;
    wait_dwr(4, found);
    chk("bp_first", {found, DOUT}, {1'b1, 8'h61});
    @(negedge CLK); #1;
    chk("bp_gap", {DWR, P0_CRDY, P1_CRDY}, {1'b0, 1'b1, 1'b0});
    @(negedge CLK); #1;
    chk("bp_second", {DWR, DOUT, P1_CRDY}, {1'b1, 8'h62, 1'b1});
    @(negedge CLK); #1;
    chk("bp_done", {DWR, ERR}, {1'b0, 2'b00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/console_arbiter.md
# console_arbiter

Shares one byte-wide console port between two Brainfuck CPU cores so both can run in the same design or testbench. Sits between the cores' console interfaces (CIN/COUT/CRDA/CACK/CWR/CRDY) and a single console device. The output path has a one-byte holding buffer per port and a round-robin drain sequencer. The input path is routed to the port that currently holds input focus.

## Interface
- DATA_WIDTH, 8, console byte width.
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset.
- P0_COUT, P1_COUT  input  DATA_WIDTH  byte written by core 0/1.
- P0_CWR, P1_CWR  input  1  one-cycle write strobe from core 0/1.
- P0_CRDY, P1_CRDY  output  1  port may accept a write (= holding buffer empty).
- P0_CIN, P1_CIN  output  DATA_WIDTH  input byte to core 0/1 (DIN passthrough).
- P0_CRDA, P1_CRDA  output  1  input byte available to this port.
- P0_CACK, P1_CACK  input  1  one-cycle consume strobe from core 0/1.
- DOUT  output  DATA_WIDTH  byte to console.
- DWR  output  1  one-cycle console write strobe.
- DRDY  input  1  console can accept a write this cycle.
- DIN  input  DATA_WIDTH  console input byte, stable while DRDA=1.
- DRDA  input  1  console input byte available.
- DACK  output  1  consume strobe to console.
- ERR  output  2  sticky overrun flag per port (bit i = port i).

## Operation
- Reset values (RESET=0, immediate): buf_v[1:0]=0, buf_d=0, DWR=0, DOUT=0, rr=0, focus=0, ERR=0, FSM=IDLE. Therefore P0_CRDY=P1_CRDY=1.
- Write capture, per port i: Pi_CWR & ~buf_v[i] → buf_d[i]<=Pi_COUT, buf_v[i]<=1.
  - Pi_CWR & buf_v[i] → byte dropped, buffer unchanged, ERR[i]<=1. ERR holds until reset.
- Pi_CRDY = ~buf_v[i], combinational from the register.
- Drain FSM, two states:
  - IDLE: if DRDY & |buf_v:
    - sel = rr if buf_v[rr], else the other port.
    - Registered: DOUT<=buf_d[sel], DWR<=1, buf_v[sel]<=0, rr<=~sel, focus<=sel.
    - Next state GAP.
  - IDLE: otherwise DWR<=0.
  - GAP: DWR<=0, then back to IDLE unconditionally. The gap gives the console one cycle to drop DRDY.
- A buffer cleared by the drain and a CWR on the same port in the same cycle: CWR was issued while CRDY=0, so it counts as overrun (dropped, ERR set).
- Input path, combinational:
  - Pi_CIN = DIN for both ports.
  - Pi_CRDA = DRDA & (focus==i).
  - DACK = DRDA & Pi_CACK of the focused port.
  - CACK from the unfocused port is ignored.
- Focus moves to the port whose byte was last issued to the console. A focus change and a CACK in the same cycle: the ACK is evaluated against the pre-edge focus.
- Arithmetic: rr and focus are single-bit and toggle/wrap naturally. No counters overflow.

## Timing
- Write latency: CWR sampled at edge k → buf_v=1 after k → DWR high for the cycle after edge k+1 (DRDY=1 at k+1). CRDY is low for exactly one cycle.
- Maximum output throughput: one byte per 2 cycles. Two simultaneous writes produce DWR pulses two cycles apart.
- DRDY=0 stalls IDLE indefinitely. Buffers hold and CRDY stays low. No byte is lost or reordered per port.
- DWR is never high for two consecutive cycles.
- RESET asserted mid-transfer aborts at once: DWR=0 and pending bytes are discarded.
- DACK and Pi_CRDA have zero latency: the same cycle as CACK/DRDA.

## Test plan
- Reset: drop RESET low during a DWR pulse → DWR=0 immediately; after release P0_CRDY=P1_CRDY=1, ERR=0, first DRDA goes to port 0.
- Single write: P0 writes 0x48 at edge k, DRDY=1 → P0_CRDY=0 for one cycle; DWR=1 with DOUT=0x48 in the cycle after k+1; exactly one pulse.
- Contention: P0 writes 0x41 and P1 writes 0x42 in the same cycle from reset → DOUT 0x41, then 0x42 two cycles later; focus=1 after both.
- Backpressure: DRDY=0 for 10 cycles with both buffers full → no DWR, both CRDY=0; on DRDY=1, bytes drain in round-robin order.
- Input routing: after P1's byte is issued, DRDA=1 with DIN=0x41 → P1_CRDA=1, P1_CIN=0x41, P0_CRDA=0; P0_CACK gives DACK=0; P1_CACK gives a one-cycle DACK in the same cycle.
- Overrun: P0_CWR with 0x55 while P0_CRDY=0 → original byte still emitted, 0x55 never appears on DOUT, ERR=2'b01 until reset.
